// File: rtl/router_pkg.sv
// router_pkg: shared router types (routing target, port index, flit and skid-buffer entry).
package router_pkg;
    localparam int NUM_OUTPUTS = 5;
    localparam int ROUTE_W = $clog2(NUM_OUTPUTS);
    typedef logic [ROUTE_W-1:0] target_t;
    typedef logic [ROUTE_W-1:0] port_idx_t;
    typedef struct packed {
        logic [3:0]  tag;
        logic [27:0] data;
    } flit_t;
    typedef struct packed {
        logic  last;
        flit_t flit;
    } skid_entry_t;
endpackage

// File: rtl/output_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 5,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          grant_valid
);
    logic [IW-1:0] idx;
    always_comb begin
        grant = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) grant = idx;
        end
    end
    assign grant_valid = |req;
endmodule

// File: rtl/output_arbiter.sv
// output_arbiter: per-output-port wormhole arbiter feeding a 2-entry registered skid buffer.
module output_arbiter
    import router_pkg::*;
#(
    parameter int NUM_INPUTS = 5,
    parameter int PORT_ID = 0,
    parameter int TARGET_W = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_INPUTS-1:0]              in_valid,
    output logic [NUM_INPUTS-1:0]              in_ready,
    input  flit_t [NUM_INPUTS-1:0]             in_flit,
    input  logic [NUM_INPUTS-1:0][TARGET_W-1:0] in_target,
    input  logic [NUM_INPUTS-1:0]              in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output flit_t                              out_flit,
    output logic                               out_last
);
    localparam int IW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]            state;
    logic [IW-1:0]         rr_ptr, owner, grant, sel, nxt;
    logic                  grant_valid, space, push, pop;
    logic [NUM_INPUTS-1:0] req;
    logic [1:0]            count;
    skid_entry_t           ent0, ent1, din;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_req
        assign req[i] = in_valid[i] && in_target[i] == TARGET_W'(PORT_ID);
    end

    rr_arbiter #(.N(NUM_INPUTS)) u_rr (
        .req         (req),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // space comes from the registered occupancy, so in_ready never sees out_ready
    assign space = count != 2'd2;
    assign sel = state == LOCKED ? owner : grant;
    assign nxt = sel == IW'(NUM_INPUTS - 1) ? '0 : sel + 1'b1;

    always_comb begin
        in_ready = '0;
        in_ready[sel] = !rst && space && (state == LOCKED ? req[owner] : grant_valid);
    end

    assign push = |(in_valid & in_ready);
    assign pop = out_valid && out_ready;
    assign din = {in_last[sel], in_flit[sel]};
    assign out_valid = count != 2'd0;
    assign out_flit = ent0.flit;
    assign out_last = ent0.last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            count <= '0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                state <= in_last[sel] ? IDLE : LOCKED;
                owner <= sel;
                if (in_last[sel]) rr_ptr <= nxt;
            end
        end
    end

    // ent0 is the output head; a push lands in the first slot left free after any pop
    always_ff @(posedge clk) begin
        if (pop) ent0 <= ent1;
        if (push && count == {1'b0, pop}) ent0 <= din;
        else if (push) ent1 <= din;
    end
endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: randomized scoreboard bench against a queue-based arbitration model.
module tb_output_arbiter;
    import router_pkg::*;
    localparam int N = 5;
    localparam int PID = 0;
    localparam int TW = 3;

    typedef struct packed {
        logic  last;
        flit_t flit;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         in_valid, in_ready, in_last;
    flit_t [N-1:0]        in_flit;
    logic [N-1:0][TW-1:0] in_target;
    logic                 out_valid, out_ready, out_last;
    flit_t                out_flit;

    output_arbiter #(.NUM_INPUTS(N), .PORT_ID(PID), .TARGET_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_flit   (in_flit),
        .in_target (in_target),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, n_out = 0;
    ent_t exp_q[$];
    int m_ptr = 0, m_owner = 0;
    bit m_locked = 0;
    logic [N-1:0] fired = '0;

    int left[N];
    logic [TW-1:0] tgt[N];
    logic [N-1:0] en = '0;
    int p_start = 0, p_bub = 0, p_rdy = 100, p_other = 0, force_len = 0, seq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // model: occupancy is the scoreboard depth; grant is the first requester from the pointer
    always @(negedge clk) begin
        logic [N-1:0] req, exp_rdy;
        int g;
        ent_t e;
        for (int i = 0; i < N; i++) req[i] = in_valid[i] && in_target[i] == TW'(PID);
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && ((req >> ((m_ptr + k) % N)) & N'(1)) != '0) g = (m_ptr + k) % N;
        exp_rdy = '0;
        if (!rst && exp_q.size() < 2) begin
            if (!m_locked && g >= 0) exp_rdy = N'(1) << g;
            if (m_locked && ((req >> m_owner) & N'(1)) != '0) exp_rdy = N'(1) << m_owner;
        end
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (!rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected flit=%h t=%0t", out_flit, $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_flit", 32'(out_flit), 32'(e.flit));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
        fired = in_valid & in_ready;
        if (rst) begin
            exp_q.delete();
            m_ptr = 0;
            m_locked = 0;
            fired = '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (fired[i]) begin
                    exp_q.push_back({in_last[i], in_flit[i]});
                    m_locked = !in_last[i];
                    m_owner = i;
                    if (in_last[i]) m_ptr = (i + 1) % N;
                end
        end
    end

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fired[i]) begin
                left[i]--;
                in_valid[i] = 1'b0;
            end
            if (in_valid[i] && in_target[i] != TW'(PID) && $urandom_range(99) < 30) begin
                in_valid[i] = 1'b0;
                left[i] = 0;
            end
            if (!in_valid[i]) begin
                if (left[i] == 0 && en[i] && $urandom_range(99) < p_start) begin
                    left[i] = force_len > 0 ? force_len : int'($urandom_range(4, 1));
                    tgt[i] = $urandom_range(99) < p_other ? TW'(PID + 1 + $urandom_range(3)) : TW'(PID);
                end
                if (left[i] > 0 && $urandom_range(99) >= p_bub) begin
                    in_valid[i] = 1'b1;
                    in_target[i] = tgt[i];
                    in_last[i] = left[i] == 1;
                    in_flit[i].tag = 4'(i);
                    in_flit[i].data = 28'(seq);
                    seq++;
                end
            end
        end
        out_ready = $urandom_range(99) < p_rdy;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) drive_cycle();
    endtask

    initial begin
        in_valid = '0;
        in_last = '0;
        in_flit = '0;
        in_target = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            tgt[i] = TW'(PID);
        end
        run(3);
        in_valid = '1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'(0));
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        in_valid = '0;
        rst = 1'b0;

        en = 5'b00100; force_len = 4; p_start = 100; p_rdy = 100;
        run(1); en = '0; run(10);
        en = 5'b01001; force_len = 3;
        run(1); en = '0; run(12);
        en = 5'b00010; force_len = 2; p_other = 100;
        run(10); en = '0; run(5);

        en = '1; force_len = 0; p_start = 30; p_bub = 30; p_rdy = 70; p_other = 15;
        run(2000);
        p_rdy = 0; run(5);
        p_rdy = 100; run(20);

        p_start = 100; p_bub = 0; p_other = 0; force_len = 1;
        run(10);
        n_out = 0;
        run(30);
        chk("throughput", 32'(n_out), 32'(30));

        force_len = 0; p_start = 30; p_bub = 30; p_rdy = 70; p_other = 15;
        run(50);
        rst = 1'b1;
        drive_cycle();
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(out_valid), 32'(0));
        run(500);

        en = '0; p_rdy = 100;
        for (int c = 0; c < 200 && (exp_q.size() > 0 || in_valid != '0); c++) drive_cycle();
        run(2);
        chk("drain_queue", 32'(exp_q.size()), 32'(0));
        chk("drain_valid", 32'(in_valid), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end
endmodule
